// File: rtl/hades_pio_out.sv
// ---------------------------------------------------------------------------
// hades_pio_out
//
// Avalon-MM write-side PIO. The CPU drives a DATA_WIDTH-bit output port
// through a small register file. Besides plain writes it supports atomic
// bit set/clear and a timed one-shot pulse that inverts the MASK bits of
// the output for a programmed number of cycles.
//
// Register map (word addresses):
//   0 DATA       RW  output data register
//   1            reserved, reads 0, writes ignored
//   2 MASK       RW  bits inverted while a pulse is running
//   3 PULSE_LEN  RW  pulse length in cycles, 0 disables the pulse
//   4 OUTSET     W   DATA <= DATA | wd        (reads 0)
//   5 OUTCLEAR   W   DATA <= DATA & ~wd       (reads 0)
//   6 PULSE_GO   W   any write (re)loads the counter from PULSE_LEN
//                R   {busy, 0..., cnt}
//   7            reserved, reads 0, writes ignored
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   chipselect  slave select
//   address     register word address
//   write_n     active-low write strobe (write = chipselect & ~write_n)
//   writedata   write data, bits above the register width are ignored
//   readdata    registered read data, zero-extended, 1-cycle latency
//   out_port    registered output port
//   pulse_busy  high while the pulse counter is nonzero
// ---------------------------------------------------------------------------
module hades_pio_out #(
    parameter int unsigned                DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0]      RESET_VALUE     = '0,
    parameter int unsigned                PULSE_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [2:0]            address,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy
);

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_RSVD1  = 3'd1,
        REG_MASK   = 3'd2,
        REG_PLEN   = 3'd3,
        REG_OUTSET = 3'd4,
        REG_OUTCLR = 3'd5,
        REG_PULSE  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_addr_e;

    reg_addr_e                  addr;
    logic                       wr;
    logic                       busy;

    logic [DATA_WIDTH-1:0]      data_q,  data_d;
    logic [DATA_WIDTH-1:0]      mask_q,  mask_d;
    logic [PULSE_CNT_WIDTH-1:0] plen_q,  plen_d;
    logic [PULSE_CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]      out_q,   out_d;

    // Upper writedata bits are architecturally ignored for narrow builds.
    logic                       unused_wd;

    assign addr      = reg_addr_e'(address);
    assign wr        = chipselect & ~write_n;
    assign busy      = (cnt_q != '0);
    assign unused_wd = ^writedata;

    // ------------------------------------------------------------------
    // Register write decode and pulse counter
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        plen_d = plen_q;
        // Counter saturates at zero; a GO write below overrides the decrement.
        cnt_d  = busy ? (cnt_q - PULSE_CNT_WIDTH'(1)) : cnt_q;

        if (wr) begin
            case (addr)
                REG_DATA:   data_d = writedata[DATA_WIDTH-1:0];
                REG_MASK:   mask_d = writedata[DATA_WIDTH-1:0];
                REG_PLEN:   plen_d = writedata[PULSE_CNT_WIDTH-1:0];
                REG_OUTSET: data_d = data_q | writedata[DATA_WIDTH-1:0];
                REG_OUTCLR: data_d = data_q & ~writedata[DATA_WIDTH-1:0];
                // Reload even while busy; a zero length cancels the pulse.
                REG_PULSE:  cnt_d  = plen_q;
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux: sampled every edge, independent of chipselect/write_n.
    // Uses the pre-edge register values, so a same-cycle write reads old.
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        case (addr)
            REG_DATA: rdata_d[DATA_WIDTH-1:0] = data_q;
            REG_MASK: rdata_d[DATA_WIDTH-1:0] = mask_q;
            REG_PLEN: rdata_d[PULSE_CNT_WIDTH-1:0] = plen_q;
            REG_PULSE: begin
                rdata_d[PULSE_CNT_WIDTH-1:0] = cnt_q;
                rdata_d[31]                  = busy;
            end
            default:  rdata_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output port: built from the registered state, so a register write
    // reaches out_port one edge after the register itself updates.
    // ------------------------------------------------------------------
    always_comb begin
        out_d = data_q ^ (mask_q & {DATA_WIDTH{busy}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            mask_q  <= '0;
            plen_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            out_q   <= RESET_VALUE;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            plen_q  <= plen_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
        end
    end

    assign readdata   = rdata_q;
    assign out_port   = out_q;
    assign pulse_busy = busy;

endmodule

// File: tb/tb_hades_pio_out.sv
// ---------------------------------------------------------------------------
// tb_hades_pio_out
//
// Scoreboard bench for hades_pio_out. The driver applies one bus cycle per
// clock and, after each rising edge, pushes the expected
// {readdata, out_port, pulse_busy} computed by a reference model. The model
// tracks the pulse as an absolute end-edge number rather than a counter.
// A monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_hades_pio_out;

    localparam int unsigned DW  = 8;
    localparam int unsigned PCW = 16;
    localparam logic [7:0]  RV  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect = 1'b0;
    logic [2:0]    address = 3'd0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          pulse_busy;

    hades_pio_out #(
        .DATA_WIDTH     (DW),
        .RESET_VALUE    (RV),
        .PULSE_CNT_WIDTH(PCW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .address   (address),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .pulse_busy(pulse_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic [7:0]  op;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (values after the most recent modelled edge).
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    int unsigned m_plen;
    longint      m_end;   // edge number at which the pulse has fully elapsed
    longint      m_edge;  // number of edges since reset release

    function automatic longint remaining(longint e);
        return (m_end > e) ? (m_end - e) : 64'sd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = RV;
        m_mask = 8'h00;
        m_plen = 0;
        m_end  = 0;
        m_edge = 0;
    endtask

    task automatic model_edge(input logic cs, input logic [2:0] a, input logic wn,
                              input logic [31:0] wd);
        exp_t   x;
        longint e;
        longint cp;
        e  = m_edge + 1;
        cp = remaining(m_edge);
        case (a)
            3'd0:    x.rd = {24'd0, m_data};
            3'd2:    x.rd = {24'd0, m_mask};
            3'd3:    x.rd = m_plen;
            3'd6:    x.rd = ((cp != 0) ? 32'h8000_0000 : 32'h0) | 32'(cp);
            default: x.rd = 32'd0;
        endcase
        x.op = m_data ^ ((cp != 0) ? m_mask : 8'h00);
        if (cs && !wn) begin
            case (a)
                3'd0:    m_data = wd[7:0];
                3'd2:    m_mask = wd[7:0];
                3'd3:    m_plen = wd & 32'h0000_FFFF;
                3'd4:    m_data = m_data | wd[7:0];
                3'd5:    m_data = m_data & ~wd[7:0];
                3'd6:    m_end  = e + longint'(m_plen);
                default: ;
            endcase
        end
        m_edge = e;
        x.busy = (remaining(e) != 0);
        sb.push_back(x);
    endtask

    task automatic step(input logic cs, input logic [2:0] a, input logic wn,
                        input logic [31:0] wd);
        @(negedge clk);
        #1;
        chipselect = cs;
        address    = a;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        model_edge(cs, a, wn, wd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b1, a, 1'b0, wd);
    endtask

    task automatic idle(input logic [2:0] a, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, a, 1'b1, 32'd0);
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear,
    // then releases it and models the first edge after release.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        #1;
        chk("async_rst_out_port", {24'd0, out_port}, {24'd0, RV});
        chk("async_rst_busy", {31'd0, pulse_busy}, 32'd0);
        chk("async_rst_readdata", readdata, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        reset     = 1'b0;
        address   = 3'd6;
        writedata = 32'd0;
        model_reset();
        @(posedge clk);
        model_edge(1'b0, 3'd6, 1'b1, 32'd0);
    endtask

    // Monitor: compare whatever the scoreboard expects for the last edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("readdata", readdata, x.rd);
                chk("out_port", {24'd0, out_port}, {24'd0, x.op});
                chk("pulse_busy", {31'd0, pulse_busy}, {31'd0, x.busy});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] r;
        logic [31:0] wd;
        logic [2:0]  a;

        reset = 1'b1;
        #1;
        chk("rst_out_port", {24'd0, out_port}, {24'd0, RV});
        chk("rst_busy", {31'd0, pulse_busy}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        model_edge(1'b0, 3'd0, 1'b1, 32'd0);

        // Plain write, set and clear.
        wr(3'd0, 32'h0000_003C);
        wr(3'd4, 32'h0000_0081);
        wr(3'd5, 32'h0000_000C);
        idle(3'd0, 3);

        // Short pulse with read-back of the counter.
        wr(3'd0, 32'h0);
        wr(3'd2, 32'h0000_000F);
        wr(3'd3, 32'd3);
        wr(3'd6, 32'h0);
        idle(3'd6, 6);

        // Restart while busy, then cancel with a zero length.
        wr(3'd3, 32'd10);
        wr(3'd6, 32'h0);
        idle(3'd6, 3);
        wr(3'd6, 32'h0);
        idle(3'd6, 16);
        wr(3'd6, 32'h0);
        idle(3'd6, 2);
        wr(3'd3, 32'd0);
        wr(3'd6, 32'h0);
        idle(3'd6, 3);

        // Reset in the middle of a pulse.
        wr(3'd3, 32'd10);
        wr(3'd6, 32'h0);
        idle(3'd6, 5);
        pulse_reset();
        idle(3'd6, 12);

        // Writes that must not land, and reads of write-only/reserved slots.
        step(1'b0, 3'd1, 1'b0, 32'hFFFF_FFFF);
        step(1'b0, 3'd7, 1'b0, 32'hFFFF_FFFF);
        step(1'b0, 3'd4, 1'b0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        idle(3'd1, 1);
        idle(3'd4, 1);
        idle(3'd5, 1);
        idle(3'd7, 1);
        idle(3'd0, 2);
        wr(3'd0, 32'hFFFF_FF5A);
        idle(3'd0, 2);

        // Randomized traffic with short pulse lengths.
        for (int i = 0; i < 400; i++) begin
            r  = $urandom();
            wd = $urandom();
            a  = r[6:4];
            if (a == 3'd3) wd = {wd[31:16], 12'd0, r[11:8]};
            step(r[0] | r[1], a, r[2] & r[3], wd);
        end

        idle(3'd0, 1);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
